// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and the MixColumns stage FSM encoding.
// Byte k of a state lives at bits [127-8k -: 8], with s[r][c] = byte 4c+r.
package aes_pkg;

  localparam int         AES_STATE_W = 128;
  localparam logic [7:0] AES_POLY    = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Constants never exceed 0x0E, so four shift-and-add steps cover every product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic int byteOffset(input int row, input int col);
    return AES_STATE_W - 1 - 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (row 0 in the top byte).
// bypass_en returns the column untouched so the final round keeps the same timing.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv_en,
  input  logic        bypass_en,
  output logic [31:0] col_out
);

  logic [7:0] w_a [4];
  logic [7:0] w_y [4];

  // Row r uses the base coefficient row rotated right by r.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_a[r] = col_in[31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      if (inv_en) begin
        w_y[r] = gmul(w_a[r], 4'hE) ^ gmul(w_a[(r+1)%4], 4'hB) ^
                 gmul(w_a[(r+2)%4], 4'hD) ^ gmul(w_a[(r+3)%4], 4'h9);
      end else begin
        w_y[r] = gmul(w_a[r], 4'h2) ^ gmul(w_a[(r+1)%4], 4'h3) ^
                 w_a[(r+2)%4] ^ w_a[(r+3)%4];
      end
    end
    col_out = bypass_en ? col_in : {w_y[0], w_y[1], w_y[2], w_y[3]};
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns stage: holds one state and rewrites COLS_PER_CYCLE columns per
// clock in place, handing the result downstream under a valid/ready handshake.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv_en,
  input  logic         bypass_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int         ITERS    = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = 2'(ITERS - 1);
  localparam logic [1:0] CPC_W    = 2'(COLS_PER_CYCLE);

  fsm_state_t   r_fsm;
  logic [1:0]   r_colCnt;
  logic [127:0] r_work;
  logic         r_inv;
  logic         r_bypass;

  logic         w_accept;
  logic [127:0] w_next;
  logic [1:0]   w_idx    [COLS_PER_CYCLE];
  logic [31:0]  w_colIn  [COLS_PER_CYCLE];
  logic [31:0]  w_colOut [COLS_PER_CYCLE];

  assign in_ready  = ~rst & ((r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_fsm == ST_DONE);
  assign state_out = r_work;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign w_idx[g]   = 2'(r_colCnt * CPC_W + 2'(g));
    assign w_colIn[g] = r_work[byteOffset(0, int'(w_idx[g])) -: 32];

    mix_column_word u_word (
      .col_in    (w_colIn[g]),
      .inv_en    (r_inv),
      .bypass_en (r_bypass),
      .col_out   (w_colOut[g])
    );
  end

  always_comb begin
    w_next = r_work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      w_next[byteOffset(0, int'(w_idx[g])) -: 32] = w_colOut[g];
    end
  end

  // An accept in DONE reloads immediately so back-to-back states see no idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm    <= ST_IDLE;
      r_colCnt <= '0;
      r_work   <= '0;
      r_inv    <= 1'b0;
      r_bypass <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_accept) begin
            r_work   <= state_in;
            r_inv    <= inv_en;
            r_bypass <= bypass_en;
            r_colCnt <= '0;
            r_fsm    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_work <= w_next;
          if (r_colCnt == LAST_CNT) begin
            r_colCnt <= '0;
            r_fsm    <= ST_DONE;
          end else begin
            r_colCnt <= r_colCnt + 2'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (w_accept) begin
              r_work   <= state_in;
              r_inv    <= inv_en;
              r_bypass <= bypass_en;
              r_colCnt <= '0;
              r_fsm    <= ST_BUSY;
            end else begin
              r_fsm <= ST_IDLE;
            end
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

endmodule
